piso_serializer_ctrl: RTL and testbench
=======================================

# piso_serializer_ctrl

Controller that sequences a parallel-in/serial-out shift datapath for streamed transmission. It accepts parallel words over a valid/ready handshake, loads them into the shift datapath, and shifts them out MSB-first with framing strobes. It enforces a configurable inter-frame idle gap and supports a synchronous flush. It sits between a word producer and any single-bit serial sink.

## Interface
- WIDTH, 4: bits per word; ≥ 2.
- GAP, 1: idle cycles forced after each frame; ≥ 0.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a word.
- in_data  input  WIDTH  word to serialize.
- in_ready  output  1  controller accepts a word this cycle.
- flush  input  1  synchronous abort of the current frame.
- s_out  output  1  serial data bit.
- s_valid  output  1  s_out carries a frame bit.
- frame_start  output  1  first bit of a frame is on s_out.
- frame_done  output  1  last bit of a frame is on s_out.
- busy  output  1  state ≠ IDLE.

## Operation
- States: IDLE, SHIFT, PARITY (macro only), GAP.
- IDLE: in_ready = 1. A handshake (in_valid & in_ready at a clock edge) loads in_data into the shift register and zeroes the bit counter, then moves to SHIFT.
- SHIFT:
  - s_out = shift_reg[WIDTH-1] and s_valid = 1.
  - Each cycle the register shifts left with 0 fill and the counter increments.
  - On the cycle with counter = WIDTH-1, the next state is PARITY if the macro is enabled. Otherwise it is GAP if GAP > 0, else IDLE.
- PARITY: one bit, with s_valid = 1. Then GAP, or IDLE if GAP = 0.
- GAP: outputs idle for GAP cycles (gap counter), then IDLE.
- frame_start = 1 only in the SHIFT cycle with counter = 0.
- frame_done = 1 only in the final bit cycle of the frame.
- flush:
  - In any state, forces IDLE on the next edge and clears the shift register and counters.
  - No frame_done is issued for an aborted frame, and no GAP follows it.
  - Flush in IDLE has no effect.
  - If flush and in_valid arrive together in IDLE, flush wins: no handshake, in_ready stays 1, nothing is loaded.
- in_data is sampled only at the handshake edge. Changes on in_data afterwards have no effect.

## Timing
- Reset values: state = IDLE; shift register and counters = 0; s_out = 0; s_valid = 0; frame_start = 0; frame_done = 0; busy = 0; in_ready = 1.
  - Reset is asynchronous: asserting it mid-frame clears state immediately.
  - Reset is released synchronously (synchronizer external).
- All outputs are registered or decoded from registered state. There is no combinational in→out path. in_ready depends only on state.
- Latency: the MSB is on s_out in the cycle after the handshake edge.
- Frame length: WIDTH cycles, or WIDTH+1 with parity.
- Minimum handshake-to-handshake period: 1 + WIDTH + P + GAP cycles, where P = 1 if parity is enabled.
- Outside bit cycles, s_out = 0 and s_valid = 0.

## Configuration
- PISO_PARITY_EN defined:
  - Adds the PARITY state.
  - The extra bit equals the XOR of the loaded word (even parity), computed and registered at the handshake.
  - frame_done moves to the parity cycle.
- PISO_PARITY_EN undefined: no PARITY state and no parity register; the frame is WIDTH bits.

## Structure
- Shared package piso_pkg:
  - state enum (IDLE, SHIFT, PARITY, GAP) with a 2-bit encoding;
  - counter-width function clog2-based for WIDTH and GAP.
- Sub-module piso_shift_core, instantiated once:
  - WIDTH-bit shift register with ports load, shift, clear, p_in, msb.
  - Same clk/reset convention.
- The controller holds the FSM, bit counter, gap counter, parity register and output decode.

## Test plan
- Reset, WIDTH=4, GAP=1, in_data=4'b1011 handshake:
  - s_out = 1,0,1,1 in cycles 1–4 after the edge, with s_valid = 1;
  - frame_start in cycle 1 and frame_done in cycle 4;
  - in_ready = 0 in cycles 1–5 and 1 in cycle 6.
- in_valid held high, GAP=0, words 4'hA then 4'h5:
  - s_out = 1,0,1,0, then one idle cycle with in_ready = 1;
  - then 0,1,0,1.
- flush asserted in the 2nd bit of 4'hF: next cycle IDLE, s_valid = 0, no frame_done; the following word 4'h8 serializes as 1,0,0,0.
- flush and in_valid together in IDLE: no load, s_valid stays 0 next cycle, in_ready = 1.
- reset asserted mid-SHIFT: all outputs take their reset values immediately without waiting for a clock edge; after release, a new frame is accepted normally.
- PISO_PARITY_EN defined, in_data=4'b1011: bits 1,0,1,1 then parity 1; frame_done is on the 5th bit.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer controller slice.
// Optional feature macro used by this slice: PISO_PARITY_EN (even-parity trailer bit).
package piso_pkg;

  // Controller states; ST_PARITY is only reachable when PISO_PARITY_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  // Bits needed to count 0..n-1, never less than one bit so a zero-length gap still has a legal counter.
  function automatic int cntWidth(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// WIDTH-bit parallel-load, left-shifting register whose MSB feeds the serial line.
// Clear has priority over load, and load over shift.
module piso_shift_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             clear,
  input  logic [WIDTH-1:0] p_in,
  output logic             msb
);

  logic [WIDTH-1:0] r_shiftReg;

  // Hold, load a new word, or shift left with zero fill so the register drains to zero after a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shiftReg <= '0;
    end else if (clear) begin
      r_shiftReg <= '0;
    end else if (load) begin
      r_shiftReg <= p_in;
    end else if (shift) begin
      r_shiftReg <= {r_shiftReg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = r_shiftReg[WIDTH-1];

endmodule

// File: rtl/piso_serializer_ctrl.sv
// PISO serializer controller: accepts words over valid/ready, shifts them out MSB-first with
// frame_start/frame_done strobes, then enforces GAP idle cycles. flush aborts a frame silently.
// Optional macro PISO_PARITY_EN appends an even-parity bit to each frame.
module piso_serializer_ctrl
  import piso_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             s_out,
  output logic             s_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int BITW = cntWidth(WIDTH);
  localparam int GAPW = cntWidth(GAP);
  localparam logic [BITW-1:0] BIT_LAST = BITW'(WIDTH - 1);
  localparam logic [GAPW-1:0] GAP_LAST = GAPW'((GAP > 0) ? GAP - 1 : 0);

  state_t          r_state;
  state_t          w_nextState;
  logic [BITW-1:0] r_bitCnt;
  logic [GAPW-1:0] r_gapCnt;
  logic            w_handshake;
  logic            w_lastBit;
  logic            w_shift;
  logic            w_msb;

  // A flush in IDLE wins over in_valid, so it blocks the handshake even though in_ready is high.
  assign w_handshake = (r_state == ST_IDLE) && in_valid && !flush;
  assign w_lastBit   = (r_state == ST_SHIFT) && (r_bitCnt == BIT_LAST);
  assign w_shift     = (r_state == ST_SHIFT);

  piso_shift_core #(
    .WIDTH(WIDTH)
  ) u_shiftCore (
    .clk   (clk),
    .reset (reset),
    .load  (w_handshake),
    .shift (w_shift),
    .clear (flush),
    .p_in  (in_data),
    .msb   (w_msb)
  );

`ifdef PISO_PARITY_EN
  logic r_parity;

  // Even parity of the word is captured at the handshake so later in_data changes cannot affect it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_parity <= 1'b0;
    end else if (flush) begin
      r_parity <= 1'b0;
    end else if (w_handshake) begin
      r_parity <= ^in_data;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; flush overrides everything and returns to IDLE without a gap.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_handshake) w_nextState = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_lastBit) begin
`ifdef PISO_PARITY_EN
          w_nextState = ST_PARITY;
`else
          w_nextState = (GAP > 0) ? ST_GAP : ST_IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        w_nextState = (GAP > 0) ? ST_GAP : ST_IDLE;
      end
`endif
      ST_GAP: begin
        if (r_gapCnt == GAP_LAST) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
    if (flush) w_nextState = ST_IDLE;
  end

  // Bit and gap counters; both return to zero when their phase ends so IDLE always sees zeros.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bitCnt <= '0;
      r_gapCnt <= '0;
    end else if (flush) begin
      r_bitCnt <= '0;
      r_gapCnt <= '0;
    end else begin
      if (w_handshake || w_lastBit) begin
        r_bitCnt <= '0;
      end else if (r_state == ST_SHIFT) begin
        r_bitCnt <= r_bitCnt + BITW'(1);
      end
      if ((r_state == ST_GAP) && (r_gapCnt != GAP_LAST)) begin
        r_gapCnt <= r_gapCnt + GAPW'(1);
      end else begin
        r_gapCnt <= '0;
      end
    end
  end

  // Output decode from registered state only, so no input reaches an output combinationally.
  always_comb begin
    s_out       = 1'b0;
    s_valid     = 1'b0;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    case (r_state)
      ST_SHIFT: begin
        s_out       = w_msb;
        s_valid     = 1'b1;
        frame_start = (r_bitCnt == '0);
`ifndef PISO_PARITY_EN
        frame_done  = w_lastBit;
`endif
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        s_out      = r_parity;
        s_valid    = 1'b1;
        frame_done = 1'b1;
      end
`endif
      default: begin
        s_out = 1'b0;
      end
    endcase
  end

  assign in_ready = (r_state == ST_IDLE);
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_piso_serializer_ctrl.sv
// Testbench for piso_serializer_ctrl: two instances (GAP=1 and GAP=0) share one stimulus stream and
// are checked every cycle against a per-instance queue of expected output records.
// Honours PISO_PARITY_EN when compiled with it.
module tb_piso_serializer_ctrl;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  // Record layout: [5]=s_valid [4]=s_out [3]=frame_start [2]=frame_done [1]=in_ready [0]=busy
  localparam int B_V   = 5;
  localparam int B_O   = 4;
  localparam int B_ST  = 3;
  localparam int B_DN  = 2;
  localparam int B_RDY = 1;
  localparam logic [15:0] IDLE_REC = 16'b10;
  localparam logic [15:0] GAP_REC  = 16'b01;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         flush;
  logic [W-1:0] in_data;
  logic [1:0]   in_ready;
  logic [1:0]   s_out;
  logic [1:0]   s_valid;
  logic [1:0]   frame_start;
  logic [1:0]   frame_done;
  logic [1:0]   busy;

  int checks = 0;
  int errors = 0;
  int gapOf[2] = '{1, 0};
  logic [15:0] expQ[2][$];
  logic [15:0] hist[2][$];

  piso_serializer_ctrl #(.WIDTH(W), .GAP(1)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[0]),
    .flush(flush), .s_out(s_out[0]), .s_valid(s_valid[0]), .frame_start(frame_start[0]),
    .frame_done(frame_done[0]), .busy(busy[0])
  );

  piso_serializer_ctrl #(.WIDTH(W), .GAP(0)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[1]),
    .flush(flush), .s_out(s_out[1]), .s_valid(s_valid[1]), .frame_start(frame_start[1]),
    .frame_done(frame_done[1]), .busy(busy[1])
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  function automatic logic [15:0] observed(input int i);
    return {10'b0, s_valid[i], s_out[i], frame_start[i], frame_done[i], in_ready[i], busy[i]};
  endfunction

  // A frame is WIDTH data bits MSB-first, an optional parity bit, then the gap cycles.
  function automatic void pushFrame(input int i, input logic [W-1:0] w);
    for (int k = 0; k < W; k++)
      expQ[i].push_back({10'b0, 1'b1, w[W-1-k], (k == 0), ((k == W-1) && (P == 0)), 1'b0, 1'b1});
    if (P == 1)
      expQ[i].push_back({10'b0, 1'b1, ^w, 1'b0, 1'b1, 1'b0, 1'b1});
    for (int g = 0; g < gapOf[i]; g++)
      expQ[i].push_back(GAP_REC);
  endfunction

  // Pack one record field over cycles from..to of the current history, earliest cycle in the MSB.
  function automatic logic [15:0] seq(input int i, input int bitPos, input int from, input int to);
    logic [15:0] r;
    r = '0;
    for (int k = from; k <= to; k++) r = {r[14:0], hist[i][k][bitPos]};
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expRec);
    checks++;
    assert (obs === expRec) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expRec);
    end
  endtask

  // One clock cycle: drive inputs, check both instances, advance the model, step past the edge.
  task automatic applyStimulus(input logic vld, input logic [W-1:0] d, input logic fl);
    logic [15:0] expRec;
    in_valid = vld;
    in_data  = d;
    flush    = fl;
    for (int i = 0; i < 2; i++) begin
      expRec = (expQ[i].size() == 0) ? IDLE_REC : expQ[i][0];
      hist[i].push_back(observed(i));
      checkOutput($sformatf("cycle_inst%0d", i), observed(i), expRec);
      if (fl) expQ[i].delete();
      else if (expQ[i].size() != 0) void'(expQ[i].pop_front());
      else if (vld) pushFrame(i, d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, W'($urandom), 1'b0);
  endtask

  task automatic clearHist();
    hist[0].delete();
    hist[1].delete();
  endtask

  initial begin
    clk      = 1'b0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    flush    = 1'b0;
    #1 reset = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) checkOutput($sformatf("reset_inst%0d", i), observed(i), IDLE_REC);
    @(posedge clk);
    #1 reset = 1'b1;

    // Single frame 1011 on the GAP=1 instance.
    clearHist();
    applyStimulus(1'b1, 4'b1011, 1'b0);
    idleCycles(7);
`ifdef PISO_PARITY_EN
    checkOutput("t1_bits",  seq(0, B_O,   1, 5), 16'b10111);
    checkOutput("t1_valid", seq(0, B_V,   1, 6), 16'b111110);
    checkOutput("t1_start", seq(0, B_ST,  1, 5), 16'b10000);
    checkOutput("t1_done",  seq(0, B_DN,  1, 5), 16'b00001);
    checkOutput("t1_ready", seq(0, B_RDY, 1, 7), 16'b0000001);
`else
    checkOutput("t1_bits",  seq(0, B_O,   1, 4), 16'b1011);
    checkOutput("t1_valid", seq(0, B_V,   1, 5), 16'b11110);
    checkOutput("t1_start", seq(0, B_ST,  1, 4), 16'b1000);
    checkOutput("t1_done",  seq(0, B_DN,  1, 4), 16'b0001);
    checkOutput("t1_ready", seq(0, B_RDY, 1, 6), 16'b000001);
`endif

    // Back-to-back words A then 5 with in_valid held high, watched on the GAP=0 instance.
    idleCycles(12);
    clearHist();
    applyStimulus(1'b1, 4'hA, 1'b0);
    repeat (10) applyStimulus(1'b1, 4'h5, 1'b0);
    idleCycles(12);
`ifdef PISO_PARITY_EN
    checkOutput("t2_bitsA", seq(1, B_O,   1, 5),   16'b10100);
    checkOutput("t2_idle",  seq(1, B_V,   6, 6),   16'b0);
    checkOutput("t2_rdy",   seq(1, B_RDY, 6, 6),   16'b1);
    checkOutput("t2_bits5", seq(1, B_O,   7, 11),  16'b01010);
`else
    checkOutput("t2_bitsA", seq(1, B_O,   1, 4),   16'b1010);
    checkOutput("t2_idle",  seq(1, B_V,   5, 5),   16'b0);
    checkOutput("t2_rdy",   seq(1, B_RDY, 5, 5),   16'b1);
    checkOutput("t2_bits5", seq(1, B_O,   6, 9),   16'b0101);
`endif

    // Flush on the second bit of F, then word 8.
    idleCycles(12);
    clearHist();
    applyStimulus(1'b1, 4'hF, 1'b0);
    applyStimulus(1'b0, W'($urandom), 1'b0);
    applyStimulus(1'b0, W'($urandom), 1'b1);
    applyStimulus(1'b1, 4'h8, 1'b0);
    idleCycles(8);
    checkOutput("t3_valid_after_flush", seq(0, B_V,   3, 3), 16'b0);
    checkOutput("t3_ready_after_flush", seq(0, B_RDY, 3, 3), 16'b1);
    checkOutput("t3_no_done",           seq(0, B_DN,  1, 3), 16'b000);
    checkOutput("t3_bits8",             seq(0, B_O,   4, 7), 16'b1000);
    checkOutput("t3_valid8",            seq(0, B_V,   4, 7), 16'b1111);

    // Flush together with in_valid while idle.
    idleCycles(12);
    clearHist();
    applyStimulus(1'b1, 4'hC, 1'b1);
    idleCycles(2);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("t4_valid_inst%0d", i), seq(i, B_V,   1, 1), 16'b0);
      checkOutput($sformatf("t4_ready_inst%0d", i), seq(i, B_RDY, 0, 1), 16'b11);
    end

    // Asynchronous reset in the middle of a frame, then a normal frame.
    idleCycles(12);
    applyStimulus(1'b1, 4'b0110, 1'b0);
    applyStimulus(1'b0, W'($urandom), 1'b0);
    applyStimulus(1'b0, W'($urandom), 1'b0);
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) checkOutput($sformatf("t5_async_inst%0d", i), observed(i), IDLE_REC);
    expQ[0].delete();
    expQ[1].delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) checkOutput($sformatf("t5_held_inst%0d", i), observed(i), IDLE_REC);
    reset = 1'b1;
    applyStimulus(1'b1, 4'b1101, 1'b0);
    idleCycles(8);

    // Randomized traffic with occasional flushes.
    repeat (400)
      applyStimulus($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 15) == 0);
    idleCycles(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
